// File: rtl/distance_packet_tx_pkg.sv
// Shared definitions for the distance-scan packet format: header bytes,
// checksum word width and the transmit framer state encoding.
package distance_packet_tx_pkg;

  localparam logic [7:0] HEADER_0 = 8'h55;
  localparam logic [7:0] HEADER_1 = 8'hAA;
  localparam int         CKSUM_W  = 16;

  typedef enum logic [3:0] {
    IDLE,
    HDR0,
    HDR1,
    CT,
    FSA_L,
    FSA_H,
    LSA_L,
    LSA_H,
    SMP_FETCH,
    SMP_L,
    SMP_H,
    CS_L,
    CS_H,
    DONE
  } tx_state_e;

endpackage

// File: rtl/distance_tx_cksum.sv
// XOR word accumulator for the frame checksum. Clear and update in the same
// cycle loads the data word directly, so the first word needs no extra cycle.
module distance_tx_cksum
  import distance_packet_tx_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               update,
  input  logic [CKSUM_W-1:0] data,
  output logic [CKSUM_W-1:0] sum
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= update ? data : '0;
    end else if (update) begin
      sum <= sum ^ data;
    end
  end

endmodule

// File: rtl/distance_packet_tx.sv
// Distance-scan packet framer: header, CT, FSA, LSA, then samples, little-endian.
// Define DISTANCE_TX_CHECKSUM_EN to append a 16-bit XOR checksum before DONE.
module distance_packet_tx
  import distance_packet_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ct_in,
  input  logic [15:0] fsa_in,
  input  logic [15:0] lsa_in,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        sample_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  tx_state_e   state, state_next;
  logic [7:0]  ct_q, cnt_q;
  logic [15:0] fsa_q, lsa_q, smp_q;
  logic        load_frame, load_sample, bump_cnt;
  logic        tx_valid_next, sample_ready_next, busy_next, frame_done_next;
  logic [7:0]  tx_byte_next;
  logic        xfer;

  assign xfer = tx_valid & tx_ready;

`ifdef DISTANCE_TX_CHECKSUM_EN
  logic [CKSUM_W-1:0] cksum;
  logic [CKSUM_W-1:0] cksum_data;

  // Header, CT, FSA and LSA fold into one word so they load in the start cycle.
  assign cksum_data = load_frame ? ({HEADER_1, HEADER_0} ^ {8'h00, ct_in} ^ fsa_in ^ lsa_in)
                                 : sample_data;

  distance_tx_cksum u_cksum (
    .clk    (clk),
    .reset  (reset),
    .clear  (load_frame),
    .update (load_frame | load_sample),
    .data   (cksum_data),
    .sum    (cksum)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ct_q         <= '0;
      cnt_q        <= '0;
      fsa_q        <= '0;
      lsa_q        <= '0;
      smp_q        <= '0;
      tx_valid     <= 1'b0;
      tx_byte      <= 8'h00;
      sample_ready <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_next;
      tx_valid     <= tx_valid_next;
      tx_byte      <= tx_byte_next;
      sample_ready <= sample_ready_next;
      busy         <= busy_next;
      frame_done   <= frame_done_next;
      if (load_frame) begin
        ct_q  <= ct_in;
        fsa_q <= fsa_in;
        lsa_q <= lsa_in;
        cnt_q <= '0;
      end
      if (load_sample) smp_q <= sample_data;
      if (bump_cnt) cnt_q <= cnt_q + 8'd1;
    end
  end

  // Outputs are registered from the next state, so every output is a flop.
  always_comb begin
    state_next        = state;
    load_frame        = 1'b0;
    load_sample       = 1'b0;
    bump_cnt          = 1'b0;
    tx_valid_next     = 1'b1;
    tx_byte_next      = 8'h00;
    sample_ready_next = 1'b0;
    busy_next         = 1'b1;
    frame_done_next   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start && (ct_in != 8'd0)) begin
          load_frame = 1'b1;
          state_next = HDR0;
        end
      end
      HDR0:  if (xfer) state_next = HDR1;
      HDR1:  if (xfer) state_next = CT;
      CT:    if (xfer) state_next = FSA_L;
      FSA_L: if (xfer) state_next = FSA_H;
      FSA_H: if (xfer) state_next = LSA_L;
      LSA_L: if (xfer) state_next = LSA_H;
      LSA_H: if (xfer) state_next = SMP_FETCH;
      SMP_FETCH: begin
        if (sample_valid) begin
          load_sample = 1'b1;
          state_next  = SMP_L;
        end
      end
      SMP_L: if (xfer) state_next = SMP_H;
      SMP_H: begin
        if (xfer) begin
          bump_cnt = 1'b1;
`ifdef DISTANCE_TX_CHECKSUM_EN
          state_next = (cnt_q + 8'd1 == ct_q) ? CS_L : SMP_FETCH;
`else
          state_next = (cnt_q + 8'd1 == ct_q) ? DONE : SMP_FETCH;
`endif
        end
      end
`ifdef DISTANCE_TX_CHECKSUM_EN
      CS_L: if (xfer) state_next = CS_H;
      CS_H: if (xfer) state_next = DONE;
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    case (state_next)
      HDR0:  tx_byte_next = HEADER_0;
      HDR1:  tx_byte_next = HEADER_1;
      CT:    tx_byte_next = ct_q;
      FSA_L: tx_byte_next = fsa_q[7:0];
      FSA_H: tx_byte_next = fsa_q[15:8];
      LSA_L: tx_byte_next = lsa_q[7:0];
      LSA_H: tx_byte_next = lsa_q[15:8];
      SMP_L: tx_byte_next = load_sample ? sample_data[7:0] : smp_q[7:0];
      SMP_H: tx_byte_next = smp_q[15:8];
`ifdef DISTANCE_TX_CHECKSUM_EN
      CS_L:  tx_byte_next = cksum[7:0];
      CS_H:  tx_byte_next = cksum[15:8];
`endif
      default: tx_valid_next = 1'b0;
    endcase

    sample_ready_next = (state_next == SMP_FETCH);
    busy_next         = (state_next != IDLE);
    frame_done_next   = (state_next == DONE);
  end

endmodule

// File: tb/tb_distance_packet_tx.sv
// Randomized self-checking bench for distance_packet_tx; the expected byte stream
// is built from the frame rules (checksum bytes when DISTANCE_TX_CHECKSUM_EN is set).
module tb_distance_packet_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ct_in;
  logic [15:0] fsa_in, lsa_in;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        sample_ready, tx_valid, tx_ready, busy, frame_done;
  logic [7:0]  tx_byte;

  always #5 clk = ~clk;

  distance_packet_tx dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ct_in        (ct_in),
    .fsa_in       (fsa_in),
    .lsa_in       (lsa_in),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .tx_valid     (tx_valid),
    .tx_byte      (tx_byte),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .frame_done   (frame_done)
  );

`ifdef DISTANCE_TX_CHECKSUM_EN
  localparam int CS_BYTES = 2;
`else
  localparam int CS_BYTES = 0;
`endif

  int num_vectors = 0;
  int num_miscompares = 0;

  int unsigned rdy_pct = 100, vld_pct = 100;
  int stall_at = -1, stall_len = 0, stall_cnt = 0;
  int starve_at = -1, starve_len = 0, starve_cnt = 0;
  int midstart_at = -1;
  bit midstart_done;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  logic [15:0] smp_list[$];
  int smp_idx, done_pulses, busy_cycles;
  bit start_next;
  logic [7:0]  ct_next;
  logic [15:0] fsa_next, lsa_next;
  bit prev_hold;
  logic [7:0] prev_byte;
  logic obs_valid, obs_busy;
  logic [7:0] obs_byte;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_vectors++;
    if (observed !== expected) begin
      num_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic fill_random(input int n);
    smp_list.delete();
    for (int i = 0; i < n; i++) smp_list.push_back(16'($urandom));
  endtask

  task automatic fill_incr(input int n);
    smp_list.delete();
    for (int i = 0; i < n; i++) smp_list.push_back(16'(i));
  endtask

  // Reference byte stream straight from the packet format.
  task automatic build_expected(input int ct, input logic [15:0] fsa, input logic [15:0] lsa);
    logic [15:0] cs;
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'(ct));
    exp_q.push_back(fsa[7:0]);
    exp_q.push_back(fsa[15:8]);
    exp_q.push_back(lsa[7:0]);
    exp_q.push_back(lsa[15:8]);
    cs = 16'hAA55 ^ 16'(ct) ^ fsa ^ lsa;
    for (int i = 0; i < ct; i++) begin
      exp_q.push_back(smp_list[i][7:0]);
      exp_q.push_back(smp_list[i][15:8]);
      cs = cs ^ smp_list[i];
    end
    if (CS_BYTES != 0) begin
      exp_q.push_back(cs[7:0]);
      exp_q.push_back(cs[15:8]);
    end
  endtask

  // One clock: observe at the falling edge, then drive inputs for the next rising edge.
  task automatic step_cycle();
    bit rdy, vld, mid;
    @(negedge clk);
    obs_valid = tx_valid;
    obs_byte  = tx_byte;
    obs_busy  = busy;
    if (busy) busy_cycles++;
    if (frame_done) begin
      done_pulses++;
      checkOutput("busy_with_done", 32'(busy), 32'd1);
    end
    if (prev_hold) begin
      checkOutput("hold_valid", 32'(tx_valid), 32'd1);
      checkOutput("hold_byte", 32'(tx_byte), 32'(prev_byte));
    end
    if (sample_ready) checkOutput("fetch_tx_valid", 32'(tx_valid), 32'd0);

    rdy = ($urandom_range(99) < rdy_pct);
    if (stall_at >= 0 && stall_cnt < stall_len &&
        (stall_cnt > 0 || (got.size() == stall_at && tx_valid))) begin
      rdy = 1'b0;
      stall_cnt++;
      checkOutput("stall_byte", 32'(tx_byte), 32'(exp_q[stall_at]));
    end
    vld = (smp_idx < smp_list.size()) && ($urandom_range(99) < vld_pct);
    if (starve_at >= 0 && starve_cnt < starve_len &&
        (starve_cnt > 0 || (smp_idx == starve_at && sample_ready))) begin
      vld = 1'b0;
      starve_cnt++;
      checkOutput("starve_ready", 32'(sample_ready), 32'd1);
      checkOutput("starve_tx_valid", 32'(tx_valid), 32'd0);
    end
    mid = (midstart_at >= 0) && !midstart_done && (got.size() == midstart_at);
    if (mid) midstart_done = 1'b1;

    start        = start_next | mid;
    ct_in        = start_next ? ct_next : (mid ? 8'd9 : 8'($urandom));
    fsa_in       = start_next ? fsa_next : 16'($urandom);
    lsa_in       = start_next ? lsa_next : 16'($urandom);
    tx_ready     = rdy;
    sample_valid = vld;
    sample_data  = vld ? smp_list[smp_idx] : 16'($urandom);

    if (tx_valid && rdy) got.push_back(tx_byte);
    if (sample_ready && vld) smp_idx++;
    prev_hold = tx_valid && !rdy;
    prev_byte = tx_byte;
  endtask

  task automatic begin_frame(input int ct, input logic [15:0] fsa, input logic [15:0] lsa);
    build_expected(ct, fsa, lsa);
    got.delete();
    smp_idx = 0; done_pulses = 0; busy_cycles = 0;
    stall_cnt = 0; starve_cnt = 0; midstart_done = 1'b0;
    ct_next = 8'(ct); fsa_next = fsa; lsa_next = lsa;
    start_next = 1'b1;
    step_cycle();
    start_next = 1'b0;
  endtask

  task automatic applyStimulus(input int ct, input logic [15:0] fsa, input logic [15:0] lsa,
                               input bit check_cycles);
    int cyc, budget;
    begin_frame(ct, fsa, lsa);
    step_cycle();
    checkOutput("first_valid", 32'(obs_valid), 32'd1);
    checkOutput("first_byte", 32'(obs_byte), 32'h55);
    budget = 60 * ct + 500;
    cyc = 0;
    while (!(done_pulses > 0 && !obs_busy) && cyc < budget) begin
      step_cycle();
      cyc++;
    end
    checkOutput("frame_end_busy", 32'(obs_busy), 32'd0);
    checkOutput("byte_count", 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      checkOutput($sformatf("byte%0d", i), 32'(got[i]), 32'(exp_q[i]));
    checkOutput("samples_taken", 32'(smp_idx), 32'(ct));
    if (check_cycles) checkOutput("frame_cycles", 32'(busy_cycles), 32'(8 + 3 * ct + CS_BYTES));
    for (int i = 0; i < 3; i++) begin
      step_cycle();
      checkOutput("idle_busy", 32'(obs_busy), 32'd0);
    end
    checkOutput("done_pulses", 32'(done_pulses), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc, n;
    reset = 1'b1; start = 1'b0; ct_in = '0; fsa_in = '0; lsa_in = '0;
    sample_valid = 1'b0; sample_data = '0; tx_ready = 1'b0;
    start_next = 1'b0; ct_next = '0; fsa_next = '0; lsa_next = '0;
    prev_hold = 1'b0; prev_byte = '0; smp_idx = 0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_byte", 32'(tx_byte), 32'd0);
    checkOutput("rst_sample_ready", 32'(sample_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b1;

    $display("[TB] basic frame");
    smp_list.delete();
    smp_list.push_back(16'h0400);
    smp_list.push_back(16'h03FF);
    applyStimulus(2, 16'h1234, 16'h5678, 1'b1);
    checkOutput("basic_last_smp", 32'((got.size() > 10) ? got[10] : 8'hxx), 32'h03);
    if (CS_BYTES != 0) begin
      checkOutput("basic_cs_lo", 32'((got.size() > 11) ? got[11] : 8'hxx), 32'hE4);
      checkOutput("basic_cs_hi", 32'((got.size() > 12) ? got[12] : 8'hxx), 32'hE9);
    end

    $display("[TB] backpressure on CT");
    fill_random(3);
    stall_at = 2; stall_len = 5;
    applyStimulus(3, 16'hA5C3, 16'h0F0F, 1'b0);
    checkOutput("stall_cycles", 32'(stall_cnt), 32'd5);
    stall_at = -1;

    $display("[TB] sample starvation");
    fill_random(3);
    starve_at = 1; starve_len = 10;
    applyStimulus(3, 16'h1111, 16'h2222, 1'b0);
    checkOutput("starve_cycles", 32'(starve_cnt), 32'd10);
    starve_at = -1;

    $display("[TB] ignored starts");
    ct_next = 8'd0; fsa_next = 16'hDEAD; lsa_next = 16'hBEEF;
    start_next = 1'b1;
    step_cycle();
    start_next = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_cycle();
      checkOutput("ct0_busy", 32'(obs_busy), 32'd0);
      checkOutput("ct0_tx_valid", 32'(obs_valid), 32'd0);
    end
    fill_random(4);
    midstart_at = 4;
    applyStimulus(4, 16'h4321, 16'h8765, 1'b1);
    checkOutput("midstart_issued", 32'(midstart_done), 32'd1);
    midstart_at = -1;

    $display("[TB] reset mid-frame");
    fill_random(3);
    rdy_pct = 100; vld_pct = 100;
    begin_frame(3, 16'h0BAD, 16'hBEEF);
    cyc = 0;
    while (got.size() < 8 && cyc < 100) begin
      step_cycle();
      cyc++;
    end
    @(posedge clk);
    #2;
    checkOutput("abort_pre_byte", 32'(tx_byte), 32'(exp_q[8]));
    reset = 1'b0;
    #1;
    checkOutput("abort_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_sample_ready", 32'(sample_ready), 32'd0);
    checkOutput("abort_tx_byte", 32'(tx_byte), 32'd0);
    done_pulses = 0;
    prev_hold = 1'b0;
    repeat (3) step_cycle();
    reset = 1'b1;
    repeat (2) step_cycle();
    checkOutput("abort_no_done", 32'(done_pulses), 32'd0);
    prev_hold = 1'b0;
    fill_random(2);
    applyStimulus(2, 16'h2468, 16'h1357, 1'b1);

    $display("[TB] random frames");
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 24);
      fill_random(n);
      rdy_pct = $urandom_range(30, 100);
      vld_pct = $urandom_range(30, 100);
      applyStimulus(n, 16'($urandom), 16'($urandom), 1'b0);
    end
    rdy_pct = 100; vld_pct = 100;

    $display("[TB] maximum count");
    fill_incr(255);
    applyStimulus(255, 16'h0000, 16'hFFFF, 1'b1);
    checkOutput("max_bytes", 32'(got.size()), 32'(517 + CS_BYTES));

    $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
    $finish;
  end

endmodule

// File: doc/distance_packet_tx.md
# distance_packet_tx

Transmit-side framer for the distance-scan packet format. Accepts a scan descriptor (sample count, first/last sample angle) plus a stream of 16-bit distance samples, and serialises them as the byte stream consumed by the distance receive path: 0x55, 0xAA, CT, FSA lo/hi, LSA lo/hi, then each sample lo/hi. It sits between the scan-data source and the UART transmitter, and is used for loopback tests and for sensor emulation.

## Interface

- HEADER_0, 8'h55, first header byte
- HEADER_1, 8'hAA, second header byte
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle frame request; sampled only in IDLE
- ct_in  input  8  sample count for the frame, 1..255
- fsa_in  input  16  first sample angle
- lsa_in  input  16  last sample angle
- sample_valid  input  1  sample_data is valid
- sample_data  input  16  distance sample
- sample_ready  output  1  block is ready to take one sample
- tx_valid  output  1  tx_byte is valid for the UART transmitter
- tx_byte  output  8  byte to transmit
- tx_ready  input  1  UART transmitter accepts a byte this cycle
- busy  output  1  frame in progress
- frame_done  output  1  single-cycle pulse after the last byte transfers

## Operation

- States: IDLE, HDR0, HDR1, CT, FSA_L, FSA_H, LSA_L, LSA_H, SMP_FETCH, SMP_L, SMP_H, [CS_L, CS_H], DONE.
- IDLE: when start=1 and ct_in!=0, latch ct_in, fsa_in and lsa_in, clear the sample counter, and go to HDR0. A start with ct_in==0 is ignored. A start outside IDLE is ignored.
- Byte states present the byte on tx_byte with tx_valid=1. On a transfer (tx_valid&tx_ready), the block advances. Bytes, in order: HEADER_0, HEADER_1, ct, fsa[7:0], fsa[15:8], lsa[7:0], lsa[15:8].
- SMP_FETCH: sample_ready=1 and tx_valid=0. When sample_valid=1, latch sample_data and go to SMP_L. SMP_L sends sample[7:0]. SMP_H sends sample[15:8], then increments the counter.
- After SMP_H transfers: if the counter equals ct, go to DONE (or CS_L when checksum is enabled); otherwise go to SMP_FETCH.
- DONE: frame_done=1 for one cycle, then return to IDLE.
- busy=1 in every state except IDLE.
- The sample counter is 8 bits wide and compared against ct. It never wraps, because ct is at most 255.
- Reset values: tx_valid=0, tx_byte=8'h00, sample_ready=0, busy=0, frame_done=0, state=IDLE, all latched fields=0.
- Reset asserted mid-frame clears everything immediately. The partial frame is abandoned and no frame_done is produced.

## Timing

- Start accepted at edge N -> tx_valid=1 with 0x55 from cycle N+1.
- tx_byte is registered. tx_byte and tx_valid hold stable until the transfer edge; no byte is dropped or repeated under backpressure.
- Header and field bytes go back-to-back: the next byte is valid in the cycle after a transfer.
- Each sample costs at least one bubble cycle (SMP_FETCH) before its low byte is presented.
- sample_ready is driven from the state only. It is never combinationally dependent on sample_valid or tx_ready.
- frame_done is asserted in the cycle after the final transfer. busy falls one cycle later.
- Minimum frame time with tx_ready tied high and samples always valid: 7 + 3·ct + 1 cycles, plus 2 cycles when the checksum is enabled.

## Configuration

- DISTANCE_TX_CHECKSUM_EN defined: after the last sample, CS_L and CS_H send a 16-bit XOR checksum, low byte first, before DONE.
  - The checksum is the XOR of these little-endian words: {HEADER_1,HEADER_0}, {8'h00,ct}, fsa, lsa, and every sample.
  - The accumulator is cleared at start acceptance.
- DISTANCE_TX_CHECKSUM_EN undefined: no checksum states and no accumulator logic; SMP_H goes straight to DONE.

## Structure

- Shared package: the state enum, the header byte constants, and the checksum word width.
- The receive path imports the same header constants from this package.
- One natural sub-module: distance_tx_cksum, a 16-bit XOR accumulator with clear and update enables. It is instantiated only under DISTANCE_TX_CHECKSUM_EN.

## Test plan

- Basic frame: ct=2, fsa=0x1234, lsa=0x5678, samples 0x0400 then 0x03FF, tx_ready=1 -> bytes 55 AA 02 34 12 78 56 00 04 FF 03, one frame_done pulse. With checksum enabled, the bytes are followed by E4 E9.
- Backpressure: tx_ready held low for 5 cycles while CT is presented -> tx_byte stays 0x02 with tx_valid=1, followed by a single transfer and no duplicate byte.
- Sample starvation: sample_valid withheld for 10 cycles -> sample_ready held at 1 and tx_valid=0 throughout; the frame completes once the sample arrives.
- Ignored starts: start with ct_in=0 -> busy stays 0. start pulsed mid-frame -> current frame unchanged and no second frame.
- Reset mid-frame: reset low during SMP_H -> tx_valid=0 and busy=0 immediately, no frame_done. The next start produces a clean frame beginning with 0x55.
- Maximum count: ct=255 with an incrementing sample pattern -> exactly 517 bytes (519 with checksum), and busy falls after frame_done.
